// File: rtl/sram_port_responder.sv
// Session-gated command responder in front of a fixed-latency SRAM port.
// Reads are tracked through a tag pipeline and returned in order.
module sram_port_responder #(
   parameter int ADDRESS_WIDTH  = 32,
   parameter int SRAMDATA_WIDTH = 32,
   parameter int TAG_WIDTH      = 2,
   parameter int MEM_ADDR_WIDTH = 16,
   parameter int READ_LATENCY   = 2
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      request,
   input  logic                      command_entry,
   input  logic                      write_enable,
   input  logic [ADDRESS_WIDTH-1:0]  address,
   input  logic [TAG_WIDTH-1:0]      tag,
   input  logic [SRAMDATA_WIDTH-1:0] data_in,
   output logic                      ready,
   output logic                      valid,
   output logic [SRAMDATA_WIDTH-1:0] query,
   output logic [TAG_WIDTH-1:0]      qtag,
   output logic                      mem_ce,
   output logic                      mem_we,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
   output logic [SRAMDATA_WIDTH-1:0] mem_wdata,
   input  logic [SRAMDATA_WIDTH-1:0] mem_rdata,
   output logic                      protocol_error,
   output logic [31:0]               read_count,
   output logic [31:0]               write_count
);

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;

   localparam logic [TAG_WIDTH-1:0] INVALID_TAG = '0;
   localparam int LAST = READ_LATENCY - 1;

   logic [1:0]  rst_sync_q;
   logic        core_run;
   state_t      state_q, state_d;
   logic        ready_q, ready_d, ready_d1_q;
   logic        accept, rd_accept, wr_accept, in_range, in_flight;
   logic        valid_q, out_live_q, perr_q;
   logic [SRAMDATA_WIDTH-1:0] query_q;
   logic [TAG_WIDTH-1:0]      qtag_q;
   logic [31:0] rd_cnt_q, wr_cnt_q;

   logic [READ_LATENCY-1:0]                stg_live_q;
   logic [READ_LATENCY-1:0]                stg_oor_q;
   logic [READ_LATENCY-1:0][TAG_WIDTH-1:0] stg_tag_q;

   // Release of reset_n is retimed so the core leaves reset on a clean edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) rst_sync_q <= 2'b00;
      else          rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign core_run = rst_sync_q[1];

   // Grace cycle: the cycle right after ready drops still accepts a command.
   assign accept    = command_entry & (ready_q | ready_d1_q);
   assign rd_accept = accept & ~write_enable;
   assign wr_accept = accept & write_enable;
   assign in_flight = (|stg_live_q) | out_live_q;

   generate
      if (ADDRESS_WIDTH > MEM_ADDR_WIDTH) begin : g_range
         assign in_range = ~|address[ADDRESS_WIDTH-1:MEM_ADDR_WIDTH];
         assign mem_addr = address[MEM_ADDR_WIDTH-1:0];
      end else begin : g_norange
         assign in_range = 1'b1;
         assign mem_addr = MEM_ADDR_WIDTH'(address);
      end
   endgenerate

   // FSM: state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)       state_q <= S_IDLE;
      else if (!core_run) state_q <= S_IDLE;
      else                state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (request) state_d = S_ACTIVE;
         S_ACTIVE: if (!request) state_d = S_DRAIN;
         S_DRAIN: begin
            if (!in_flight) begin
               if (request)          state_d = S_ACTIVE;
               else if (!ready_d1_q) state_d = S_IDLE;
            end
         end
         default:  state_d = S_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      ready_d   = (state_q == S_ACTIVE) && request;
      mem_ce    = reset_n & accept & in_range;
      mem_we    = reset_n & wr_accept & in_range;
      mem_wdata = data_in;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ready_q    <= 1'b0;
         ready_d1_q <= 1'b0;
      end else if (!core_run) begin
         ready_q    <= 1'b0;
         ready_d1_q <= 1'b0;
      end else begin
         ready_q    <= ready_d;
         ready_d1_q <= ready_q;
      end
   end

   // Tag pipeline, one stage per cycle of memory read latency.
   genvar gi;
   generate
      for (gi = 0; gi < READ_LATENCY; gi++) begin : g_stage
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               stg_live_q[gi] <= 1'b0;
               stg_oor_q[gi]  <= 1'b0;
               stg_tag_q[gi]  <= '0;
            end else if (!core_run) begin
               stg_live_q[gi] <= 1'b0;
               stg_oor_q[gi]  <= 1'b0;
               stg_tag_q[gi]  <= '0;
            end else if (gi == 0) begin
               stg_live_q[gi] <= rd_accept;
               stg_oor_q[gi]  <= ~in_range;
               stg_tag_q[gi]  <= tag;
            end else begin
               stg_live_q[gi] <= stg_live_q[(gi > 0) ? gi-1 : 0];
               stg_oor_q[gi]  <= stg_oor_q[(gi > 0) ? gi-1 : 0];
               stg_tag_q[gi]  <= stg_tag_q[(gi > 0) ? gi-1 : 0];
            end
         end
      end
   endgenerate

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid_q    <= 1'b0;
         out_live_q <= 1'b0;
         query_q    <= '0;
         qtag_q     <= '0;
      end else if (!core_run) begin
         valid_q    <= 1'b0;
         out_live_q <= 1'b0;
         query_q    <= '0;
         qtag_q     <= '0;
      end else begin
         out_live_q <= stg_live_q[LAST];
         if (stg_live_q[LAST] && stg_tag_q[LAST] != INVALID_TAG) begin
            valid_q <= 1'b1;
            query_q <= stg_oor_q[LAST] ? '0 : mem_rdata;
            qtag_q  <= stg_tag_q[LAST];
         end else begin
            valid_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
         perr_q   <= 1'b0;
      end else if (!core_run) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
         perr_q   <= 1'b0;
      end else begin
         if (rd_accept && rd_cnt_q != 32'hFFFF_FFFF) rd_cnt_q <= rd_cnt_q + 32'd1;
         if (wr_accept && wr_cnt_q != 32'hFFFF_FFFF) wr_cnt_q <= wr_cnt_q + 32'd1;
         if (command_entry && !accept) perr_q <= 1'b1;
      end
   end

   assign ready          = ready_q;
   assign valid          = valid_q;
   assign query          = query_q;
   assign qtag           = qtag_q;
   assign protocol_error = perr_q;
   assign read_count     = rd_cnt_q;
   assign write_count    = wr_cnt_q;

endmodule

// File: tb/tb_sram_port_responder.sv
// Directed bench for sram_port_responder with a behavioural 2-cycle SRAM.
module tb_sram_port_responder;

   localparam int RL = 2;

   logic        clock, reset_n, request, command_entry, write_enable;
   logic [31:0] address, data_in;
   logic [1:0]  tag;
   logic        ready, valid, mem_ce, mem_we, protocol_error;
   logic [31:0] query, mem_wdata, mem_rdata, read_count, write_count;
   logic [1:0]  qtag;
   logic [15:0] mem_addr;

   int n_assert = 0;
   int n_fail   = 0;

   logic [31:0] mem [0:65535];
   logic [31:0] pipe [RL];
   logic [1:0]  b_tag [4] = '{2'd1, 2'd2, 2'd1, 2'd3};

   sram_port_responder #(
      .ADDRESS_WIDTH(32), .SRAMDATA_WIDTH(32), .TAG_WIDTH(2),
      .MEM_ADDR_WIDTH(16), .READ_LATENCY(RL)
   ) dut (
      .clock(clock), .reset_n(reset_n), .request(request),
      .command_entry(command_entry), .write_enable(write_enable),
      .address(address), .tag(tag), .data_in(data_in),
      .ready(ready), .valid(valid), .query(query), .qtag(qtag),
      .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .protocol_error(protocol_error),
      .read_count(read_count), .write_count(write_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // SRAM model: data appears RL cycles after a read strobe; junk otherwise.
   always @(posedge clock) begin
      if (!reset_n) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + 32'(i);
         mem[5] <= 32'hA5A5_0001;
      end else if (mem_ce && mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
      pipe[0] <= (mem_ce && !mem_we) ? mem[mem_addr] : 32'hBAD0_BAD0;
      for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
   end
   assign mem_rdata = pipe[RL-1];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", name, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic cmd(input logic we, input logic [31:0] addr, input logic [1:0] t, input logic [31:0] d);
      command_entry = 1'b1;
      write_enable  = we;
      address       = addr;
      tag           = t;
      data_in       = d;
      $display("cmd we=%0b addr=%h tag=%0d data=%h", we, addr, t, d);
   endtask

   task automatic idle();
      command_entry = 1'b0;
      write_enable  = 1'b0;
      address       = '0;
      tag           = '0;
      data_in       = '0;
   endtask

   task automatic wait_ready();
      int k = 0;
      while (ready !== 1'b1 && k < 20) begin
         tick();
         k++;
      end
      check("wait_ready", {31'd0, ready}, 32'd1);
   endtask

   initial begin
      reset_n = 1'b0;
      request = 1'b0;
      idle();
      tick(); tick(); tick();

      // Reset state
      check("rst_ready", {31'd0, ready}, 32'd0);
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_query", query, 32'd0);
      check("rst_qtag", {30'd0, qtag}, 32'd0);
      check("rst_perr", {31'd0, protocol_error}, 32'd0);
      check("rst_rdcnt", read_count, 32'd0);
      check("rst_wrcnt", write_count, 32'd0);
      check("rst_ce", {31'd0, mem_ce}, 32'd0);

      // Release: ready must stay low for at least two edges
      request = 1'b1;
      reset_n = 1'b1;
      tick();
      check("rel_ready_e1", {31'd0, ready}, 32'd0);
      tick();
      check("rel_ready_e2", {31'd0, ready}, 32'd0);
      wait_ready();

      // Basic read of address 5, tag 1
      cmd(1'b0, 32'd5, 2'd1, 32'd0);
      #1;
      check("rd_ce", {31'd0, mem_ce}, 32'd1);
      check("rd_we", {31'd0, mem_we}, 32'd0);
      check("rd_addr", {16'd0, mem_addr}, 32'd5);
      tick(); idle();
      check("rd_valid_c1", {31'd0, valid}, 32'd0);
      tick();
      check("rd_valid_c2", {31'd0, valid}, 32'd0);
      tick();
      $display("resp valid=%0b qtag=%0d query=%h", valid, qtag, query);
      check("rd_valid_c3", {31'd0, valid}, 32'd1);
      check("rd_query", query, 32'hA5A5_0001);
      check("rd_qtag", {30'd0, qtag}, 32'd1);
      check("rd_count", read_count, 32'd1);
      tick();
      check("rd_valid_c4", {31'd0, valid}, 32'd0);
      check("rd_query_hold", query, 32'hA5A5_0001);

      // Write then read address 7
      cmd(1'b1, 32'd7, 2'd0, 32'hDEAD_BEEF);
      #1;
      check("wr_ce", {31'd0, mem_ce}, 32'd1);
      check("wr_we", {31'd0, mem_we}, 32'd1);
      check("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
      tick();
      cmd(1'b0, 32'd7, 2'd2, 32'd0);
      #1;
      check("wr_rd_we", {31'd0, mem_we}, 32'd0);
      check("wr_rd_ce", {31'd0, mem_ce}, 32'd1);
      tick(); idle();
      #1;
      check("wr_idle_we", {31'd0, mem_we}, 32'd0);
      check("wr_count", write_count, 32'd1);
      tick(); tick();
      $display("resp valid=%0b qtag=%0d query=%h", valid, qtag, query);
      check("wr_rd_valid", {31'd0, valid}, 32'd1);
      check("wr_rd_query", query, 32'hDEAD_BEEF);
      check("wr_rd_qtag", {30'd0, qtag}, 32'd2);
      tick();

      // Back-to-back reads 0..3, then a tag-0 read that must not respond
      for (int k = 0; k < 9; k++) begin
         if (k < 4)       cmd(1'b0, 32'(k), b_tag[k], 32'd0);
         else if (k == 4) cmd(1'b0, 32'd1, 2'd0, 32'd0);
         else             idle();
         #1;
         if (k >= 3 && k <= 6) begin
            $display("resp valid=%0b qtag=%0d query=%h", valid, qtag, query);
            check("b2b_valid", {31'd0, valid}, 32'd1);
            check("b2b_qtag", {30'd0, qtag}, {30'd0, b_tag[k-3]});
            check("b2b_query", query, 32'h1000_0000 + 32'(k-3));
         end else if (k >= 7) begin
            check("b2b_tag0_novalid", {31'd0, valid}, 32'd0);
         end
         tick();
      end
      check("b2b_count", read_count, 32'd7);

      // Request drops during a read burst: grace accept, then drop
      request = 1'b0;
      cmd(1'b0, 32'd0, 2'd1, 32'd0);
      #1;
      check("drp_ce0", {31'd0, mem_ce}, 32'd1);
      tick();
      check("drp_ready_low", {31'd0, ready}, 32'd0);
      cmd(1'b0, 32'd1, 2'd2, 32'd0);
      #1;
      check("drp_grace_ce", {31'd0, mem_ce}, 32'd1);
      tick();
      cmd(1'b0, 32'd2, 2'd3, 32'd0);
      #1;
      check("drp_late_ce", {31'd0, mem_ce}, 32'd0);
      tick(); idle();
      request = 1'b1;
      #1;
      check("drp_perr", {31'd0, protocol_error}, 32'd1);
      check("drp_v1", {31'd0, valid}, 32'd1);
      check("drp_t1", {30'd0, qtag}, 32'd1);
      check("drp_q1", query, 32'h1000_0000);
      check("drp_rdy_x3", {31'd0, ready}, 32'd0);
      tick();
      check("drp_v2", {31'd0, valid}, 32'd1);
      check("drp_t2", {30'd0, qtag}, 32'd2);
      check("drp_q2", query, 32'h1000_0001);
      check("drp_rdy_x4", {31'd0, ready}, 32'd0);
      tick();
      check("drp_v3_none", {31'd0, valid}, 32'd0);
      check("drp_rdy_x5", {31'd0, ready}, 32'd0);
      tick();
      check("drp_rdy_x6", {31'd0, ready}, 32'd0);
      tick();
      check("drp_rdy_x7", {31'd0, ready}, 32'd1);
      check("drp_count", read_count, 32'd9);

      // Out-of-range read and write
      cmd(1'b0, 32'h0001_0000, 2'd1, 32'd0);
      #1;
      check("oor_rd_ce", {31'd0, mem_ce}, 32'd0);
      tick();
      cmd(1'b1, 32'h0001_0000, 2'd0, 32'h1234_5678);
      #1;
      check("oor_wr_ce", {31'd0, mem_ce}, 32'd0);
      check("oor_wr_we", {31'd0, mem_we}, 32'd0);
      tick(); idle();
      tick();
      check("oor_valid", {31'd0, valid}, 32'd1);
      check("oor_query", query, 32'd0);
      check("oor_qtag", {30'd0, qtag}, 32'd1);
      check("oor_wrcnt", write_count, 32'd2);
      check("oor_rdcnt", read_count, 32'd10);
      tick();

      // Reset with two reads in flight
      cmd(1'b0, 32'd0, 2'd1, 32'd0);
      tick();
      cmd(1'b0, 32'd1, 2'd2, 32'd0);
      tick();
      cmd(1'b0, 32'd2, 2'd3, 32'd0);
      reset_n = 1'b0;
      #1;
      check("mrst_ce", {31'd0, mem_ce}, 32'd0);
      check("mrst_we", {31'd0, mem_we}, 32'd0);
      check("mrst_ready", {31'd0, ready}, 32'd0);
      check("mrst_valid", {31'd0, valid}, 32'd0);
      check("mrst_qtag", {30'd0, qtag}, 32'd0);
      check("mrst_rdcnt", read_count, 32'd0);
      check("mrst_wrcnt", write_count, 32'd0);
      check("mrst_perr", {31'd0, protocol_error}, 32'd0);
      idle();
      tick(); tick();
      reset_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         check("mrst_no_valid", {31'd0, valid}, 32'd0);
      end
      check("mrst_rdcnt_after", read_count, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
